// File: rtl/ccff_chain_loader_pkg.sv
// ccff_chain_loader_pkg: shared state encoding and CRC-8 constants for the chain loader.
package ccff_chain_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;
  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    return (c << 1) ^ ((c[7] ^ b) ? CRC_POLY : 8'h00);
  endfunction
endpackage

// File: rtl/ccff_chain_loader_crc.sv
// ccff_crc8_serial: bit-serial MSB-first CRC-8 with synchronous clear and enable.
module ccff_crc8_serial
  import ccff_chain_loader_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [7:0] crc_o
);
  logic [7:0] crc_q, crc_d;
  always_comb crc_d = clr_i ? CRC_INIT : en_i ? crc8_step(crc_q, bit_i) : crc_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) crc_q <= CRC_INIT;
    else crc_q <= crc_d;
  assign crc_o = crc_q;
endmodule

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams a word-wide bitstream MSB-first into a configuration
// flip-flop chain and CRCs the bits returned from the chain tail.
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [7:0]        tail_crc
);
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BC_W  = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);
  state_e            state_q, state_d;
  logic [WORD_W-1:0] bits_q, bits_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d, take;
  logic [CNT_W-1:0]  acc_q, acc_d, sh_q, sh_d;
  logic [31:0]       rem;
  logic              load, xfer, clr;
  // A word is only credited with the bits still needed, so the tail of the final word is never shifted.
  always_comb begin
    load = state_q == LOAD;
    clr = state_q == IDLE && start;
    ccff_shift_en = load && bcnt_q != '0 && sh_q < LEN;
    ccff_head = ccff_shift_en & bits_q[WORD_W-1];
    s_ready = load && acc_q < LEN && (bcnt_q == '0 || (bcnt_q == BC_W'(1) && ccff_shift_en));
    xfer = s_valid && s_ready;
    rem = 32'(CHAIN_LEN) - 32'(acc_q);
    take = rem < 32'(WORD_W) ? BC_W'(rem) : BC_W'(WORD_W);
    busy = load;
    done = state_q == DONE;
  end
  always_comb begin
    sh_d = clr ? '0 : sh_q + CNT_W'(ccff_shift_en);
    acc_d = clr ? '0 : xfer ? acc_q + CNT_W'(take) : acc_q;
    bits_d = clr ? '0 : xfer ? s_data : ccff_shift_en ? bits_q << 1 : bits_q;
    bcnt_d = clr ? '0 : xfer ? take : bcnt_q - BC_W'(ccff_shift_en);
    state_d = clr ? LOAD : (load && sh_d == LEN) ? DONE : done ? IDLE : state_q;
  end
  always_ff @(posedge prog_clk or posedge prog_reset)
    if (prog_reset) begin
      state_q <= IDLE;
      bits_q <= '0;
      bcnt_q <= '0;
      acc_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      bits_q <= bits_d;
      bcnt_q <= bcnt_d;
      acc_q <= acc_d;
      sh_q <= sh_d;
    end
  ccff_crc8_serial u_crc (
    .clk_i(prog_clk),
    .rst_i(prog_reset),
    .clr_i(clr),
    .en_i (ccff_shift_en),
    .bit_i(ccff_tail),
    .crc_o(tail_crc)
  );
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: randomized loads into 16- and 12-stage behavioural chains,
// checked against bitstream/polynomial-division reference values.
module tb_ccff_chain_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst[2], st[2], sv[2], rdy[2], en[2], hd[2], tl[2], bz[2], dn[2], pl[2];
  logic [7:0] sd[2], crc[2];
  logic [15:0] chain[2] = '{16'h0, 16'h0};
  logic [15:0] plv[2];
  int checks = 0, errors = 0, cyc = 0;
  int nsh[2] = '{0, 0}, ndone[2] = '{0, 0}, base[2] = '{0, 0};
  int first_sh[2] = '{0, 0}, last_sh[2] = '{0, 0}, done_cyc[2] = '{0, 0};
  logic [31:0] hbits[2] = '{0, 0}, tbits[2] = '{0, 0};
  logic [7:0] crc_log[2][1024];

  ccff_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) u_dut16 (
    .prog_clk(clk), .prog_reset(rst[0]), .start(st[0]), .s_data(sd[0]), .s_valid(sv[0]),
    .s_ready(rdy[0]), .ccff_head(hd[0]), .ccff_shift_en(en[0]), .ccff_tail(tl[0]),
    .busy(bz[0]), .done(dn[0]), .tail_crc(crc[0]));
  ccff_chain_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_dut12 (
    .prog_clk(clk), .prog_reset(rst[1]), .start(st[1]), .s_data(sd[1]), .s_valid(sv[1]),
    .s_ready(rdy[1]), .ccff_head(hd[1]), .ccff_shift_en(en[1]), .ccff_tail(tl[1]),
    .busy(bz[1]), .done(dn[1]), .tail_crc(crc[1]));

  assign tl[0] = chain[0][15];
  assign tl[1] = chain[1][11];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CRC as the remainder of M(x)*x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [31:0] v, input int n);
    logic [39:0] r;
    r = 40'(v) << 8;
    for (int k = n + 7; k >= 8; k--) if (r[k]) r = r ^ (40'h107 << (k - 8));
    return r[7:0];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++)
      if (pl[i]) chain[i] <= plv[i];
      else if (en[i]) chain[i] <= {chain[i][14:0], hd[i]};
  end

  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      crc_log[i][nsh[i] & 1023] = crc[i];
      if (en[i]) begin
        if (nsh[i] == base[i]) first_sh[i] = cyc;
        hbits[i] = {hbits[i][30:0], hd[i]};
        tbits[i] = {tbits[i][30:0], tl[i]};
        last_sh[i] = cyc;
        nsh[i]++;
      end else check("head_idle", 32'(hd[i]), 0);
      if (dn[i]) begin
        ndone[i]++;
        done_cyc[i] = cyc;
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int i, input int n);
    sv[i] = 1'b0;
    repeat (n) tick();
  endtask

  task automatic preload(input int i, input logic [15:0] v);
    pl[i] = 1'b1;
    plv[i] = v;
    tick();
    pl[i] = 1'b0;
  endtask

  task automatic start_load(input int i);
    st[i] = 1'b1;
    tick();
    st[i] = 1'b0;
    base[i] = nsh[i];
    check("busy_start", 32'(bz[i]), 1);
  endtask

  task automatic send(input int i, input logic [7:0] w);
    int t = 0;
    sv[i] = 1'b1;
    sd[i] = w;
    while (!rdy[i] && t < 100) begin
      tick();
      t++;
    end
    check("send_timeout", 32'(t < 100), 1);
    tick();
  endtask

  task automatic reset_outputs(input int i);
    check("rst_ready", 32'(rdy[i]), 0);
    check("rst_shift_en", 32'(en[i]), 0);
    check("rst_head", 32'(hd[i]), 0);
    check("rst_busy", 32'(bz[i]), 0);
    check("rst_done", 32'(dn[i]), 0);
    check("rst_crc", 32'(crc[i]), 0);
  endtask

  task automatic do_load(input int i, input logic [7:0] w0, input logic [7:0] w1,
                         input int rgap, input bit gap, input bit poke);
    int len, nd, t, s;
    logic [31:0] pre, exp, m;
    len = i == 0 ? 16 : 12;
    m = (32'd1 << len) - 1;
    pre = 32'(chain[i]) & m;
    exp = 32'({w0, w1}) >> (16 - len);
    nd = ndone[i];
    start_load(i);
    idle(i, $urandom_range(0, rgap));
    send(i, w0);
    if (poke) begin
      sv[i] = 1'b0;
      st[i] = 1'b1;
      tick();
      st[i] = 1'b0;
    end
    if (gap) begin
      idle(i, 8);
      s = nsh[i];
      for (int k = 0; k < 5; k++) begin
        check("gap_shift_en", 32'(en[i]), 0);
        check("gap_head", 32'(hd[i]), 0);
        tick();
      end
      check("gap_hold", nsh[i] - s, 0);
    end else idle(i, $urandom_range(0, rgap));
    send(i, w1);
    check("ready_after_last", 32'(rdy[i]), 0);
    sv[i] = 1'b0;
    t = 0;
    while (ndone[i] == nd && t < 100) begin
      tick();
      t++;
    end
    repeat (3) tick();
    check("done_count", ndone[i] - nd, 1);
    check("shifts", nsh[i] - base[i], len);
    check("head_bits", hbits[i] & m, exp);
    check("tail_bits", tbits[i] & m, pre);
    check("chain", 32'(chain[i]) & m, exp);
    check("crc", 32'(crc[i]), 32'(crc_ref(pre, len)));
    check("done_latency", done_cyc[i] - last_sh[i], 1);
    if (rgap == 0 && !gap && !poke) check("shift_span", last_sh[i] - first_sh[i], len - 1);
    check("busy_end", 32'(bz[i]), 0);
  endtask

  task automatic abort_load();
    int t = 0, nd;
    start_load(0);
    send(0, 8'hC3);
    sv[0] = 1'b0;
    while (nsh[0] - base[0] < 5 && t < 100) begin
      tick();
      t++;
    end
    check("abort_shifts", nsh[0] - base[0], 5);
    nd = ndone[0];
    rst[0] = 1'b1;
    #1;
    reset_outputs(0);
    tick();
    tick();
    rst[0] = 1'b0;
    check("abort_no_done", ndone[0] - nd, 0);
    do_load(0, 8'h69, 8'h96, 0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      st[i] = 1'b0;
      sv[i] = 1'b0;
      sd[i] = 8'h00;
      pl[i] = 1'b0;
      plv[i] = 16'h0;
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) reset_outputs(i);
    preload(0, 16'h8000);
    preload(1, 16'h0ABC);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    do_load(0, 8'h00, 8'h00, 0, 1'b0, 1'b0);
    check("crc_after_1", 32'(crc_log[0][(base[0] + 1) & 1023]), 32'h07);
    check("tail_0x8000", tbits[0] & 32'hFFFF, 32'h8000);
    do_load(0, 8'hA5, 8'h3C, 0, 1'b0, 1'b0);
    check("head_a53c", hbits[0] & 32'hFFFF, 32'hA53C);
    do_load(1, 8'hFF, 8'hF0, 0, 1'b0, 1'b0);
    check("head_fff", hbits[1] & 32'hFFF, 32'hFFF);
    do_load(0, 8'h5A, 8'hC6, 0, 1'b1, 1'b0);
    do_load(1, 8'($urandom), 8'($urandom), 2, 1'b0, 1'b1);
    abort_load();
    repeat (24) begin
      int i;
      i = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) preload(i, 16'($urandom));
      do_load(i, 8'($urandom), 8'($urandom), 3, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
